// File: rtl/sdft_scheduler_if.sv
// Bundles the ADC input, SDFT command/response and line-buffer write signals of the scheduler.
interface sdft_scheduler_if #(
   parameter int data_w    = 8,
   parameter int freq_bins = 320,
   parameter int freq_w    = 16
);
   localparam int bin_addr_w = $clog2(freq_bins);

   logic [data_w-1:0]     adc_sample;
   logic                  adc_valid;
   logic [data_w-1:0]     sdft_sample;
   logic                  sdft_start;
   logic                  sdft_read;
   logic [bin_addr_w-1:0] sdft_bin_addr;
   logic                  sdft_ready;
   logic [freq_w-1:0]     sdft_bin_out;
   logic                  line_wr_en;
   logic [bin_addr_w-1:0] line_wr_addr;
   logic [freq_w-1:0]     line_wr_data;
   logic                  line_done;
   logic                  overrun;

   modport master (
      input  adc_sample, adc_valid, sdft_ready, sdft_bin_out,
      output sdft_sample, sdft_start, sdft_read, sdft_bin_addr,
      output line_wr_en, line_wr_addr, line_wr_data, line_done, overrun
   );

   modport slave (
      output adc_sample, adc_valid, sdft_ready, sdft_bin_out,
      input  sdft_sample, sdft_start, sdft_read, sdft_bin_addr,
      input  line_wr_en, line_wr_addr, line_wr_data, line_done, overrun
   );
endinterface

// File: rtl/sdft_scheduler.sv
// Feeds ADC samples to a sliding DFT and dumps its bins into a waterfall line buffer once per line.
// Define SDFT_SCHED_OVERRUN_EN to expose the sticky overrun flag for dropped samples.
module sdft_scheduler #(
   parameter int data_w           = 8,
   parameter int freq_bins        = 320,
   parameter int freq_w           = 16,
   parameter int SAMPLES_PER_LINE = 64,
   parameter int READ_SKEW        = 2
) (
   input logic              clk,
   input logic              reset_n,
   sdft_scheduler_if.master bus
);
   localparam int bin_addr_w = $clog2(freq_bins);
   localparam int RD_W       = $clog2(freq_bins + READ_SKEW);
   localparam int SC_W       = (SAMPLES_PER_LINE > 1) ? $clog2(SAMPLES_PER_LINE) : 1;

   localparam logic [RD_W-1:0] RD_LAST = RD_W'(freq_bins + READ_SKEW - 1);
   localparam logic [RD_W-1:0] RD_SKEW = RD_W'(READ_SKEW);
   localparam logic [RD_W-1:0] RD_BINS = RD_W'(freq_bins);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLES_PER_LINE - 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_START      = 3'd1;
   localparam logic [2:0] S_CALC_WAIT  = 3'd2;
   localparam logic [2:0] S_RD_ISSUE   = 3'd3;
   localparam logic [2:0] S_RD_WAIT    = 3'd4;
   localparam logic [2:0] S_RD_CAPTURE = 3'd5;
   localparam logic [2:0] S_LINE_END   = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [data_w-1:0]     pend_data_q, pend_data_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [SC_W-1:0]       samp_cnt_q, samp_cnt_d;
   logic [RD_W-1:0]       rd_idx_q, rd_idx_d;
   logic                  dump_q, dump_d;
   logic                  seen_low_q, seen_low_d;
   logic                  overrun_q, overrun_d;
   logic [data_w-1:0]     sdft_sample_q, sdft_sample_d;
   logic                  sdft_start_q, sdft_start_d;
   logic                  sdft_read_q, sdft_read_d;
   logic [bin_addr_w-1:0] sdft_bin_addr_q, sdft_bin_addr_d;
   logic                  line_wr_en_q, line_wr_en_d;
   logic [bin_addr_w-1:0] line_wr_addr_q, line_wr_addr_d;
   logic [freq_w-1:0]     line_wr_data_q, line_wr_data_d;
   logic                  line_done_q, line_done_d;
   logic                  consume_s;

   // The trailing READ_SKEW reads only flush the pipeline, so they re-read the last bin.
   function automatic logic [bin_addr_w-1:0] rd_addr(input logic [RD_W-1:0] r);
      if (r < RD_BINS) begin
         return bin_addr_w'(r);
      end else begin
         return bin_addr_w'(freq_bins - 1);
      end
   endfunction

   // Next-state, command and pending-sample logic.
   always_comb begin
      state_d         = state_q;
      pend_data_d     = pend_data_q;
      pend_vld_d      = pend_vld_q;
      samp_cnt_d      = samp_cnt_q;
      rd_idx_d        = rd_idx_q;
      dump_d          = dump_q;
      seen_low_d      = seen_low_q;
      sdft_sample_d   = sdft_sample_q;
      sdft_start_d    = 1'b0;
      sdft_read_d     = 1'b0;
      sdft_bin_addr_d = sdft_bin_addr_q;
      line_wr_en_d    = 1'b0;
      line_wr_addr_d  = line_wr_addr_q;
      line_wr_data_d  = line_wr_data_q;
      line_done_d     = 1'b0;
      consume_s       = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A waiting sample always wins over the next dump read.
            if (pend_vld_q && bus.sdft_ready) begin
               consume_s     = 1'b1;
               sdft_start_d  = 1'b1;
               sdft_sample_d = pend_data_q;
               state_d       = S_START;
            end else if (dump_q && bus.sdft_ready) begin
               sdft_read_d     = 1'b1;
               sdft_bin_addr_d = rd_addr(rd_idx_q);
               state_d         = S_RD_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            seen_low_d = 1'b0;
            state_d    = S_CALC_WAIT;
         end
         S_CALC_WAIT: begin
            if (!bus.sdft_ready) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               state_d = S_IDLE;
               if (samp_cnt_q == SC_LAST) begin
                  samp_cnt_d = {SC_W{1'b0}};
                  dump_d     = 1'b1;
                  rd_idx_d   = {RD_W{1'b0}};
               end else begin
                  samp_cnt_d = samp_cnt_q + SC_W'(1);
               end
            end else begin
               state_d = S_CALC_WAIT;
            end
         end
         S_RD_ISSUE: begin
            seen_low_d = 1'b0;
            state_d    = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (!bus.sdft_ready) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               state_d = S_RD_CAPTURE;
            end else begin
               state_d = S_RD_WAIT;
            end
         end
         S_RD_CAPTURE: begin
            if (rd_idx_q >= RD_SKEW) begin
               line_wr_en_d   = 1'b1;
               line_wr_addr_d = bin_addr_w'(rd_idx_q - RD_SKEW);
               line_wr_data_d = bus.sdft_bin_out;
            end else begin
               line_wr_en_d = 1'b0;
            end
            if (rd_idx_q == RD_LAST) begin
               rd_idx_d = {RD_W{1'b0}};
               state_d  = S_LINE_END;
            end else begin
               rd_idx_d = rd_idx_q + RD_W'(1);
               state_d  = S_IDLE;
            end
         end
         S_LINE_END: begin
            line_done_d = 1'b1;
            dump_d      = 1'b0;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The slot frees in the consuming cycle, so a simultaneous strobe refills it without loss.
      if (consume_s) begin
         pend_vld_d  = bus.adc_valid;
         pend_data_d = bus.adc_valid ? bus.adc_sample : pend_data_q;
      end else if (bus.adc_valid && !pend_vld_q) begin
         pend_vld_d  = 1'b1;
         pend_data_d = bus.adc_sample;
      end else begin
         pend_vld_d  = pend_vld_q;
         pend_data_d = pend_data_q;
      end

`ifdef SDFT_SCHED_OVERRUN_EN
      overrun_d = overrun_q | (bus.adc_valid & pend_vld_q & ~consume_s);
`else
      overrun_d = 1'b0;
`endif
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         pend_data_q     <= {data_w{1'b0}};
         pend_vld_q      <= 1'b0;
         samp_cnt_q      <= {SC_W{1'b0}};
         rd_idx_q        <= {RD_W{1'b0}};
         dump_q          <= 1'b0;
         seen_low_q      <= 1'b0;
         overrun_q       <= 1'b0;
         sdft_sample_q   <= {data_w{1'b0}};
         sdft_start_q    <= 1'b0;
         sdft_read_q     <= 1'b0;
         sdft_bin_addr_q <= {bin_addr_w{1'b0}};
         line_wr_en_q    <= 1'b0;
         line_wr_addr_q  <= {bin_addr_w{1'b0}};
         line_wr_data_q  <= {freq_w{1'b0}};
         line_done_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         pend_data_q     <= pend_data_d;
         pend_vld_q      <= pend_vld_d;
         samp_cnt_q      <= samp_cnt_d;
         rd_idx_q        <= rd_idx_d;
         dump_q          <= dump_d;
         seen_low_q      <= seen_low_d;
         overrun_q       <= overrun_d;
         sdft_sample_q   <= sdft_sample_d;
         sdft_start_q    <= sdft_start_d;
         sdft_read_q     <= sdft_read_d;
         sdft_bin_addr_q <= sdft_bin_addr_d;
         line_wr_en_q    <= line_wr_en_d;
         line_wr_addr_q  <= line_wr_addr_d;
         line_wr_data_q  <= line_wr_data_d;
         line_done_q     <= line_done_d;
      end
   end

   assign bus.sdft_sample   = sdft_sample_q;
   assign bus.sdft_start    = sdft_start_q;
   assign bus.sdft_read     = sdft_read_q;
   assign bus.sdft_bin_addr = sdft_bin_addr_q;
   assign bus.line_wr_en    = line_wr_en_q;
   assign bus.line_wr_addr  = line_wr_addr_q;
   assign bus.line_wr_data  = line_wr_data_q;
   assign bus.line_done     = line_done_q;
   assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_sdft_scheduler.sv
// Self-checking bench for sdft_scheduler: directed vector table, corner sequences and a random run
// checked against a sample-queue / line-content reference model.
module tb_sdft_scheduler;
   localparam int DW  = 8;
   localparam int FB  = 8;
   localparam int FW  = 16;
   localparam int SPL = 4;
   localparam int RS  = 2;
`ifdef SDFT_SCHED_OVERRUN_EN
   localparam int EXP_OVR = 1;
`else
   localparam int EXP_OVR = 0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sdft_scheduler_if #(.data_w(DW), .freq_bins(FB), .freq_w(FW)) bus ();

   sdft_scheduler #(
      .data_w(DW), .freq_bins(FB), .freq_w(FW), .SAMPLES_PER_LINE(SPL), .READ_SKEW(RS)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // SDFT model: busy 3 cycles per command, magnitude = 100 + address issued two reads earlier.
   int          busy    = 0;
   logic [2:0]  h1      = 3'd0;
   logic [2:0]  h2      = 3'd0;
   logic [FW-1:0] bin_out_r = 16'd0;
   always @(posedge clk) begin
      if (bus.sdft_start || bus.sdft_read) busy <= 3;
      else if (busy > 0) busy <= busy - 1;
      if (bus.sdft_read) begin
         h2        <= h1;
         h1        <= bus.sdft_bin_addr;
         bin_out_r <= 16'd100 + {13'd0, h2};
      end
   end
   assign bus.sdft_ready   = (busy == 0);
   assign bus.sdft_bin_out = bin_out_r;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference state: samples expected to reach the SDFT in order, plus line progress.
   logic [7:0] exp_q[$];
   int   n_start = 0, n_read = 0, n_write = 0, n_done = 0;
   int   reads_line = 0, wr_idx = 0, reads_at_start = 0;
   logic [7:0] last_start = 8'd0;
   logic [7:0] hold_val   = 8'd0;
   bit   hold_on = 1'b0, hold_seen0 = 1'b0, prev_ready = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            wr_idx     = 0;
            reads_line = 0;
            hold_on    = 1'b0;
         end else begin
            if (bus.sdft_start || bus.sdft_read) begin
               chk("start_read_exclusive", int'(bus.sdft_start & bus.sdft_read), 0);
               chk("ready_before_cmd", int'(prev_ready), 1);
            end
            if (hold_on) begin
               if (bus.sdft_ready && hold_seen0) begin
                  hold_on = 1'b0;
               end else begin
                  chk("sample_hold", int'(bus.sdft_sample), int'(hold_val));
                  if (!bus.sdft_ready) hold_seen0 = 1'b1;
               end
            end
            if (bus.sdft_start) begin
               n_start++;
               last_start     = bus.sdft_sample;
               reads_at_start = reads_line;
               hold_on        = 1'b1;
               hold_seen0     = 1'b0;
               hold_val       = bus.sdft_sample;
               chk("start_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) chk("start_sample", int'(bus.sdft_sample), int'(exp_q.pop_front()));
            end
            if (bus.sdft_read) begin
               n_read++;
               reads_line++;
            end
            if (bus.line_wr_en) begin
               n_write++;
               chk("wr_addr", int'(bus.line_wr_addr), wr_idx);
               chk("wr_data", int'(bus.line_wr_data), 100 + wr_idx);
               wr_idx++;
            end
            if (bus.line_done) begin
               n_done++;
               chk("line_writes", wr_idx, FB);
               chk("line_reads", reads_line, FB + RS);
               wr_idx     = 0;
               reads_line = 0;
            end
         end
         prev_ready = bus.sdft_ready;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n       = 1'b0;
      bus.adc_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("rst_start",     int'(bus.sdft_start), 0);
      chk("rst_read",      int'(bus.sdft_read), 0);
      chk("rst_sample",    int'(bus.sdft_sample), 0);
      chk("rst_bin_addr",  int'(bus.sdft_bin_addr), 0);
      chk("rst_wr_en",     int'(bus.line_wr_en), 0);
      chk("rst_wr_addr",   int'(bus.line_wr_addr), 0);
      chk("rst_wr_data",   int'(bus.line_wr_data), 0);
      chk("rst_line_done", int'(bus.line_done), 0);
      chk("rst_overrun",   int'(bus.overrun), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // One-cycle strobe; the next strobe may follow 'gap' cycles later (gap >= 2).
   task automatic send(input logic [7:0] v, input bit expect_it, input int gap);
      @(posedge clk); #1;
      bus.adc_sample = v;
      bus.adc_valid  = 1'b1;
      if (expect_it) exp_q.push_back(v);
      @(posedge clk); #1;
      bus.adc_valid = 1'b0;
      repeat (gap - 2) @(posedge clk);
   endtask

   task automatic wait_done(input int target, input int budget, input string nm);
      for (int c = 0; c < budget && n_done < target; c++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk(nm, n_done, target);
   endtask

   typedef struct {
      logic [7:0] sample;
      int gap;
      int d_start;
      int d_read;
      int d_write;
      int d_done;
   } vec_t;

   vec_t tbl[4];
   int   s0, r0, w0, d0, wr_before;

   initial begin
      tbl[0] = '{8'h40, 20, 1, 0, 0, 0};
      tbl[1] = '{8'h41, 20, 1, 0, 0, 0};
      tbl[2] = '{8'h42, 20, 1, 0, 0, 0};
      tbl[3] = '{8'h43, 150, 1, FB + RS, FB, 1};
      bus.adc_valid  = 1'b0;
      bus.adc_sample = 8'h00;

      // Single samples, then a full line.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         s0 = n_start; r0 = n_read; w0 = n_write; d0 = n_done;
         send(tbl[i].sample, 1'b1, tbl[i].gap);
         chk("tbl_starts", n_start - s0, tbl[i].d_start);
         chk("tbl_reads",  n_read - r0,  tbl[i].d_read);
         chk("tbl_writes", n_write - w0, tbl[i].d_write);
         chk("tbl_done",   n_done - d0,  tbl[i].d_done);
         chk("tbl_sample", int'(last_start), int'(tbl[i].sample));
      end

      // A sample arriving mid-dump is started between reads and counts toward the next line.
      do_reset();
      d0 = n_done;
      for (int i = 0; i < 3; i++) send(8'(8'h50 + i), 1'b1, 20);
      send(8'h53, 1'b1, 30);
      send(8'h55, 1'b1, 20);
      chk("mid_dump_start_between_reads", int'(reads_at_start > 0 && reads_at_start < FB + RS), 1);
      wait_done(d0 + 1, 200, "mid_dump_line1_done");
      for (int i = 0; i < 3; i++) send(8'(8'h56 + i), 1'b1, 20);
      wait_done(d0 + 2, 250, "mid_dump_line2_done");

      // Reset during read 5 abandons the line; the next line is complete.
      do_reset();
      d0 = n_done;
      for (int i = 0; i < 4; i++) send(8'(8'h60 + i), 1'b1, 20);
      for (int c = 0; c < 200 && reads_line < 6; c++) @(posedge clk);
      chk("reached_read5", reads_line, 6);
      wr_before = wr_idx;
      do_reset();
      chk("aborted_partial", int'(wr_before < FB), 1);
      repeat (20) @(posedge clk);
      chk("aborted_no_done", n_done, d0);
      for (int i = 0; i < 4; i++) send(8'(8'h70 + i), 1'b1, 20);
      wait_done(d0 + 1, 200, "after_abort_line_done");

      // Back-to-back strobes: second held pending, third dropped.
      do_reset();
      s0 = n_start;
      send(8'hA1, 1'b1, 2);
      send(8'hA2, 1'b1, 2);
      send(8'hA3, 1'b0, 40);
      chk("drop_starts", n_start - s0, 2);
      chk("drop_queue_empty", exp_q.size(), 0);
      chk("overrun_set", int'(bus.overrun), EXP_OVR);
      send(8'hA4, 1'b1, 40);
      chk("overrun_sticky", int'(bus.overrun), EXP_OVR);

      // Random samples, spaced so no drop and no line overlap can occur.
      do_reset();
      s0 = n_start;
      d0 = n_done;
      for (int i = 0; i < 16; i++) send(8'($urandom), 1'b1, $urandom_range(40, 60));
      wait_done(d0 + 4, 400, "rand_lines");
      chk("rand_starts", n_start - s0, 16);
      chk("rand_queue_empty", exp_q.size(), 0);
      chk("rand_overrun", int'(bus.overrun), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sdft_scheduler.md
SDFT_SCHEDULER -- requirements
Module: sdft_scheduler

Interface
REQ-001 SHALL have parameter data_w, default 8, sample width.
REQ-002 SHALL have parameter freq_bins, default 320, number of SDFT bins; bin_addr_w = $clog2(freq_bins).
REQ-003 SHALL have parameter freq_w, default 16, bin magnitude width.
REQ-004 SHALL have parameter SAMPLES_PER_LINE, default 64, SDFT updates per waterfall line.
REQ-005 SHALL have parameter READ_SKEW, default 2, read transactions between a bin address being issued and its magnitude appearing on sdft_bin_out.
REQ-006 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 adc_sample  in  data_w  ADC sample; adc_valid  in  1  one-cycle strobe qualifying adc_sample.
REQ-009 sdft_sample  out  data_w; sdft_start  out  1; sdft_read  out  1; sdft_bin_addr  out  bin_addr_w: SDFT command outputs.
REQ-010 sdft_ready  in  1  SDFT idle; sdft_bin_out  in  freq_w  SDFT magnitude output.
REQ-011 line_wr_en  out  1; line_wr_addr  out  bin_addr_w; line_wr_data  out  freq_w: line-buffer write port.
REQ-012 line_done  out  1  one-cycle pulse after the last bin of a line is written; overrun  out  1  sticky sample-drop flag.

Function
REQ-013 SHALL use states IDLE, START, CALC_WAIT, RD_ISSUE, RD_WAIT, RD_CAPTURE, LINE_END.
REQ-014 Any adc_valid SHALL load a one-entry pending register (sample + valid bit), independent of state.
REQ-015 IDLE: if pending valid and sdft_ready=1 -> START; else if a dump is in progress -> RD_ISSUE; else stay.
REQ-016 START: sdft_sample <= pending sample, sdft_start=1 for exactly one cycle, pending cleared, -> CALC_WAIT.
REQ-017 sdft_sample SHALL stay stable from START until sdft_ready is next observed 1.
REQ-018 CALC_WAIT: wait at least one cycle with sdft_ready=0, then on sdft_ready=1 increment sample counter; if counter reached SAMPLES_PER_LINE-1, clear counter and start a dump (read index r=0); -> IDLE.
REQ-019 Dump: freq_bins+READ_SKEW read transactions, r = 0 .. freq_bins+READ_SKEW-1; sdft_bin_addr = r for r < freq_bins, else freq_bins-1.
REQ-020 RD_ISSUE: requires sdft_ready=1; sdft_read=1 for exactly one cycle -> RD_WAIT; sdft_start and sdft_read SHALL never be 1 in the same cycle.
REQ-021 RD_WAIT: on sdft_ready=1 (after having seen 0) -> RD_CAPTURE.
REQ-022 RD_CAPTURE: if r >= READ_SKEW, line_wr_en=1 for one cycle with line_wr_addr=r-READ_SKEW, line_wr_data=sdft_bin_out; r increments; if r was final -> LINE_END, else -> IDLE (a pending sample is serviced before the next read).
REQ-023 LINE_END: line_done=1 for one cycle, dump flag cleared, -> IDLE.
REQ-024 Samples arriving during a dump SHALL be processed and counted toward the next line.
REQ-025 adc_valid while pending already valid and not being consumed that cycle: new sample dropped, older kept, overrun set; adc_valid in the same cycle as consumption (START) loads pending with no overrun.
REQ-026 Each line SHALL produce exactly freq_bins writes at addresses 0..freq_bins-1 in ascending order.

Reset
REQ-027 reset_n=0 SHALL asynchronously force: state IDLE, all outputs 0, counters and r 0, pending empty, dump flag clear, overrun 0.
REQ-028 After reset mid-operation, the first START or RD_ISSUE SHALL occur only after sdft_ready is sampled 1; a partially written line is abandoned without line_done.

Configuration
REQ-029 Macro SDFT_SCHED_OVERRUN_EN: defined -> overrun behaves as REQ-025 and clears only on reset; undefined -> overrun tied 0, drops still occur silently.

Verification (freq_bins=8, SAMPLES_PER_LINE=4, READ_SKEW=2; SDFT model: ready low 3 cycles per command, bin_out = 100+addr issued two reads earlier)
REQ-030 Reset, then adc_valid 8'h40 -> one sdft_start pulse, sdft_sample=8'h40 held until ready returns, no read.
REQ-031 4 samples spaced 20 cycles -> 10 reads, 8 writes addr 0..7 with data 100..107, one line_done.
REQ-032 adc_valid every 2 cycles, 3 samples -> 2nd held pending, 3rd dropped, overrun=1 (0 with macro undefined).
REQ-033 Sample arriving mid-dump -> start issued between two reads, written data still 100..107, sample counted toward next line.
REQ-034 reset_n low during dump read 5, then 4 new samples -> no line_done for the aborted line, next line writes 0..7 complete.
